// File: rtl/spi_sub.sv
// SPI mode-0 subordinate: 2-bit length header followed by a 128/192/256-bit payload,
// with a 128-bit reply word shifted out on miso during the frame.
module spi_sub #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cs_n,
    input  logic         sclk,
    input  logic         mosi,
    output logic         miso,
    input  logic [127:0] tx_data,
    output logic [255:0] rx_data,
    output logic [1:0]   rx_mode,
    output logic         rx_valid,
    output logic         rx_err,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   cs_prev;
    logic                   sclk_prev;
    logic                   armed;
    logic [8:0]             cnt;
    logic [1:0]             hdr;
    logic [255:0]           rx_sh;
    logic [127:0]           tx_sh;

    logic         cs_s, sclk_s, mosi_s;
    logic         cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [8:0]   exp_total;
    logic [255:0] aligned;
    logic         good;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // The fill chain marks when the synchronisers hold real samples rather than reset
    // values, so a cs_n already low at reset release is never mistaken for a frame start.
    assign cs_fall   = armed & cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    always_comb begin
        exp_total = 9'h1ff;
        aligned   = rx_sh;
        case (hdr)
            2'b00: begin
                exp_total = 9'd130;
                aligned   = rx_sh << 128;
            end
            2'b01: begin
                exp_total = 9'd194;
                aligned   = rx_sh << 64;
            end
            2'b10: exp_total = 9'd258;
            default: exp_total = 9'h1ff;
        endcase
        good = (hdr != 2'b11) && (cnt == exp_total);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            fill      <= '0;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            cs_sync[0]   <= cs_n;
            sclk_sync[0] <= sclk;
            mosi_sync[0] <= mosi;
            fill[0]      <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i]   <= cs_sync[i-1];
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                fill[i]      <= fill[i-1];
            end
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
            armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hdr      <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            rx_data  <= '0;
            rx_mode  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
            miso     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        state <= HDR;
                        cnt   <= '0;
                        hdr   <= '0;
                        rx_sh <= '0;
                        tx_sh <= tx_data;
                        miso  <= tx_data[127];
                        busy  <= 1'b1;
                    end
                end
                HDR, PAYLOAD: begin
                    // Bits past 258 are dropped; the counter holds at 258.
                    if (sclk_rise && cnt < 9'd258) begin
                        cnt <= cnt + 9'd1;
                        if (state == HDR) begin
                            hdr <= {hdr[0], mosi_s};
                            if (cnt == 9'd1) state <= PAYLOAD;
                        end else begin
                            rx_sh <= {rx_sh[254:0], mosi_s};
                        end
                    end
                    if (sclk_fall) begin
                        tx_sh <= tx_sh << 1;
                        miso  <= tx_sh[126];
                    end
                    // Assigned last so a same-cycle sclk edge is counted before closing.
                    if (cs_rise) state <= DONE;
                end
                DONE: begin
                    if (good) begin
                        rx_data  <= aligned;
                        rx_mode  <= hdr;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    miso  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_sub.md
SPI_SUB -- requirements
Module: spi_sub

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops synchronising cs_n, sclk and mosi into clk.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cs_n, input, 1 bit: SPI chip select from the initiator, active low; frames the transfer.
REQ-005 SHALL have port sclk, input, 1 bit: SPI serial clock, mode 0 (idles low).
REQ-006 SHALL have port mosi, input, 1 bit: serial data from the initiator, MSB first.
REQ-007 SHALL have port miso, output, 1 bit: serial data to the initiator, MSB first.
REQ-008 SHALL have port tx_data, input, 128 bits: reply word, sampled at frame start.
REQ-009 SHALL have port rx_data, output, 256 bits: received payload, left-aligned.
REQ-010 SHALL have port rx_mode, output, 2 bits: header of the last good frame (00=128, 01=192, 10=256 payload bits).
REQ-011 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a good frame completes.
REQ-012 SHALL have port rx_err, output, 1 bit: one-cycle pulse when a bad frame completes.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-014 SHALL pass cs_n, sclk and mosi through SYNC_STAGES flops, then detect edges on the synchronised signals; sclk high and low phases are at least 2 clk periods each.
REQ-015 SHALL use four states: IDLE, HDR, PAYLOAD and DONE.
REQ-016 SHALL move IDLE->HDR on a synchronised cs_n falling edge, clear the bit counter, load tx_data into the 128-bit tx shadow and assert busy.
REQ-017 SHALL sample mosi on each synchronised sclk rising edge.
REQ-018 SHALL shift the first 2 sampled bits into the header; the first bit is header[1].
REQ-019 SHALL move HDR->PAYLOAD after 2 bits and set the expected payload length from the header: 00->128, 01->192, 10->256, 11->invalid.
REQ-020 SHALL shift payload bits in PAYLOAD into a 256-bit register MSB-first, so the first payload bit lands at bit 255 once the frame completes.
REQ-021 SHALL saturate the bit counter at 258 (9 bits) and discard any bits beyond 258 without shifting.
REQ-022 SHALL move to DONE on a synchronised cs_n rising edge in HDR or PAYLOAD.
REQ-023 SHALL, in DONE, treat a frame as good if the header is not 11 and the payload count exactly equals the expected length.
REQ-024 SHALL, for a good frame, update rx_data and rx_mode, zero the unused low bits of rx_data, and pulse rx_valid for one cycle.
REQ-025 SHALL, for any other frame, leave rx_data and rx_mode unchanged and pulse rx_err for one cycle.
REQ-026 SHALL return DONE->IDLE in 1 cycle and deassert busy in that cycle.
REQ-027 SHALL drive miso from bit 127 of the tx shadow from the cs_n fall onward.
REQ-028 SHALL shift the tx shadow left on each synchronised sclk falling edge during a frame.
REQ-029 SHALL drive miso to 0 after 128 falling edges and whenever the block is in IDLE.
REQ-030 SHALL ignore tx_data changes during a frame.
REQ-031 SHALL give sclk edge detection priority when a cs_n rising edge and an sclk edge fall in the same cycle: the bit is counted, then the frame closes.
REQ-032 SHALL never assert rx_valid and rx_err in the same cycle.

Reset
REQ-033 SHALL, while rst_n is low, force state IDLE, synchronisers to idle levels (cs_n=1, sclk=0, mosi=0), rx_data=0, rx_mode=00, rx_valid=0, rx_err=0, busy=0, miso=0, counter=0 and tx shadow=0.
REQ-034 SHALL abort a reset asserted mid-frame with no rx_valid or rx_err pulse.
REQ-035 SHALL, after reset release, ignore a frame whose cs_n is already low until cs_n goes high and then low again.

Verification
REQ-036 SHALL cover: 130-bit frame, header 00, payload 000102030405060708090a0b0c0d0e0f -> rx_valid pulse, rx_mode=00, rx_data=000102...0e0f followed by 128 zero bits.
REQ-037 SHALL cover: 194-bit frame, header 01, payload 000102...1617 -> rx_mode=01, rx_data upper 192 bits=000102...1617, low 64 bits=0.
REQ-038 SHALL cover: 258-bit frame, header 10, payload 000102...1e1f -> rx_valid, rx_data=000102...1e1f.
REQ-039 SHALL cover: tx_data=69c4e0d86a7b0430d8cdb78070b4c55a with a 130-bit frame -> miso returns that word MSB-first on the first 128 sclk periods, then 0.
REQ-040 SHALL cover: 100-bit frame with header 00, then a frame with header 11 -> rx_err pulses twice, no rx_valid, rx_data keeps its previous value.
REQ-041 SHALL cover: rst_n low after 60 bits of a 258-bit frame -> all outputs at reset values, no pulse; the next full frame is received correctly.
